priority_encoder_rr: RTL and testbench
======================================

# priority_encoder_rr

Parametrised, registered N-to-log2(N) priority encoder with an output valid/ready handshake. It is the sequential successor to the combinational 8-to-3 encoder. Mode is selectable: fixed priority (highest index wins) or round-robin, where a rotating pointer gives fair selection among simultaneous requests. It sits between request-generating logic and a single consumer that accepts one encoded index per handshake.

## Interface
Parameters:
- N, default 8: number of request lines; legal range 2..256; need not be a power of two.
- W, default $clog2(N): width of the encoded index; derived, never overridden.
- RR_MODE, default 0: 0 = fixed priority (highest set index wins); 1 = round-robin.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- reset, input, 1: synchronous, active-high reset.
- enable, input, 1: when 0, no new request vector is sampled.
- d, input, N: request vector; bit i set = request i active.
- ready, input, 1: consumer accepts the current y this cycle when valid=1.
- y, output, W: registered encoded index of the selected request.
- valid, output, 1: y holds an unaccepted result.
- multi, output, 1: registered with y; 1 if more than one bit of d was set at capture.

## Operation
- Load condition: load = enable && (|d) && (!valid || ready).
- On load, the block registers the selected index into y, sets valid=1, and sets multi = (popcount(d) > 1).
- On a handshake (valid && ready) with no load, valid goes to 0. y and multi keep their last value.
- While valid && !ready, y, multi and valid hold. d is ignored and the request is not re-evaluated.
- If enable=0 or d=0 while the output slot is free, there is no load. valid falls or stays 0.
- Fixed mode (RR_MODE=0): select the highest set index of d. The pointer is unused and stays 0.
- Round-robin mode (RR_MODE=1):
  - Internal pointer ptr (W bits, range 0..N-1).
  - Select the first set bit scanning ptr, ptr+1, …, N-1, 0, …, ptr-1.
  - On load with selected index k, ptr <= (k == N-1) ? 0 : k+1.
  - ptr wraps at N-1, not at 2^W-1. This matters for non-power-of-two N.
- ptr changes only on load, never on handshake alone.
- Reset values: y=0, valid=0, multi=0, ptr=0. Reset wins over every other condition on the same edge and discards any outstanding result.

## Timing
- Latency: d sampled at edge t appears on y/valid after edge t (1 cycle).
- Throughput: one result per cycle when ready is held at 1 and requests are present.
- Simultaneous handshake and load in the same cycle: the new result replaces the old one. valid stays 1 with no bubble.
- ready is a don't-care while valid=0.
- Reset asserted mid-handshake: after the edge, valid=0 regardless of ready or d. The first load is possible on the first edge with reset=0.
- No combinational path from d, enable or ready to any output.

## Test plan
- Reset: hold reset=1 for 2 cycles with d=8'hFF and enable=1 → y=0, valid=0, multi=0. First edge after release → y=7 (fixed mode), valid=1.
- Fixed-mode one-hot sweep, N=8, ready=1: d=1<<i for i=0..7 → y=i one cycle later, valid=1, multi=0. Then d=8'hFF → y=7, multi=1. Then d=0 → valid=0.
- Round-robin fairness, N=8, RR_MODE=1, d=8'hFF held, ready=1 → y sequence 0,1,2,…,7,0,1. With d=8'b1000_0100 → y alternates 2,7,2,7.
- Backpressure: valid=1, y=3, ready=0 for 4 cycles while d changes to 8'h80 → y stays 3 and valid stays 1. Raise ready → next cycle y=7.
- Non-power-of-two wrap, N=5, W=3, RR_MODE=1, d=5'b11111 → y sequence 0,1,2,3,4,0. ptr never reaches 5–7.
- Enable gating and mid-operation reset:
  - enable=0 with d=8'h10 → valid stays 0.
  - Reset pulse while valid=1 and ready=0 → valid=0, ptr=0. Next round-robin grant with d=8'hFF is y=0.

Source files
------------

// File: rtl/priority_encoder_rr.sv
// priority_encoder_rr: registered N-to-W priority encoder with a
// valid/ready output slot and fixed or round-robin selection.
module priority_encoder_rr #(
    parameter int N       = 8,
    parameter int W       = $clog2(N),
    parameter int RR_MODE = 0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         enable,
    input  logic [N-1:0] d,
    input  logic         ready,
    output logic [W-1:0] y,
    output logic         valid,
    output logic         multi
);

    logic [W-1:0] ptr;
    logic [W-1:0] ptr_nxt;
    logic [W-1:0] sel;
    logic [W-1:0] sel_top;
    logic [W-1:0] sel_hi;
    logic [W-1:0] sel_lo;
    logic         found_hi;
    logic         load;
    logic         many;

    // A new vector is taken only when the output slot is free or
    // is being emptied by the consumer in this same cycle.
    assign load = enable && (|d) && (!valid || ready);

    // Clearing the lowest set bit leaves something iff 2+ bits set.
    assign many = |(d & (d - N'(1)));

    // Candidates: highest set bit; lowest set bit at/above ptr;
    // lowest set bit overall (used when the scan wraps past N-1).
    always_comb begin
        sel_top  = '0;
        sel_hi   = '0;
        sel_lo   = '0;
        found_hi = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (d[i]) begin
                sel_top = W'(i);
            end
        end
        for (int i = N - 1; i >= 0; i--) begin
            if (d[i]) begin
                sel_lo = W'(i);
                if (i >= int'(ptr)) begin
                    sel_hi   = W'(i);
                    found_hi = 1'b1;
                end
            end
        end
    end

    assign sel = (RR_MODE != 0)
               ? (found_hi ? sel_hi : sel_lo)
               : sel_top;

    // Pointer wraps at N-1 so non-power-of-two N never leaves range.
    assign ptr_nxt = (sel == W'(N - 1)) ? '0 : sel + W'(1);

    // Output slot and round-robin pointer; reset discards any result.
    always_ff @(posedge clk) begin
        if (reset) begin
            y     <= '0;
            valid <= 1'b0;
            multi <= 1'b0;
            ptr   <= '0;
        end else if (load) begin
            y     <= sel;
            valid <= 1'b1;
            multi <= many;
            if (RR_MODE != 0) begin
                ptr <= ptr_nxt;
            end
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_priority_encoder_rr.sv
// tb_priority_encoder_rr: scoreboard bench for fixed, round-robin
// and N=5 round-robin encoder instances sharing clock and reset.
module tb_priority_encoder_rr;

    typedef struct packed {
        logic [2:0] y;
        logic       m;
    } exp_t;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       ready = 1'b1;
    logic [7:0] d     = 8'hFF;
    logic [2:0] en    = 3'b001;

    logic [2:0] y0, y1, y2;
    logic       v0, v1, v2;
    logic       m0, m1, m2;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    priority_encoder_rr #(.N(8), .RR_MODE(0)) u_fix (
        .clk    (clk),
        .reset  (reset),
        .enable (en[0]),
        .d      (d),
        .ready  (ready),
        .y      (y0),
        .valid  (v0),
        .multi  (m0)
    );

    priority_encoder_rr #(.N(8), .RR_MODE(1)) u_rr (
        .clk    (clk),
        .reset  (reset),
        .enable (en[1]),
        .d      (d),
        .ready  (ready),
        .y      (y1),
        .valid  (v1),
        .multi  (m1)
    );

    priority_encoder_rr #(.N(5), .RR_MODE(1)) u_n5 (
        .clk    (clk),
        .reset  (reset),
        .enable (en[2]),
        .d      (d[4:0]),
        .ready  (ready),
        .y      (y2),
        .valid  (v2),
        .multi  (m2)
    );

    task automatic check(input string name,
                         input logic [7:0] act,
                         input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic spurious(input string name, input logic [2:0] yy);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: valid=1 y=%0d with nothing expected", name, yy);
    endtask

    task automatic push(input int id, input int yy, input bit mm);
        exp_t e;
        e.y = 3'(yy);
        e.m = mm;
        case (id)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic step(input logic [7:0] dd,
                        input logic [2:0] ee,
                        input logic rr);
        @(posedge clk);
        #1;
        d     = dd;
        en    = ee;
        ready = rr;
    endtask

    // Monitors: compare the presented result with the queue head;
    // the head is retired only when the consumer accepts it.
    always @(negedge clk) begin
        if (!reset && v0 === 1'b1) begin
            if (q0.size() == 0) begin
                spurious("fix_spurious", y0);
            end else begin
                check("fix_y_multi", {4'h0, y0, m0},
                      {4'h0, q0[0].y, q0[0].m});
                if (ready) void'(q0.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (!reset && v1 === 1'b1) begin
            if (q1.size() == 0) begin
                spurious("rr_spurious", y1);
            end else begin
                check("rr_y_multi", {4'h0, y1, m1},
                      {4'h0, q1[0].y, q1[0].m});
                if (ready) void'(q1.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (!reset && v2 === 1'b1) begin
            if (q2.size() == 0) begin
                spurious("n5_spurious", y2);
            end else begin
                check("n5_y_multi", {4'h0, y2, m2},
                      {4'h0, q2[0].y, q2[0].m});
                if (ready) void'(q2.pop_front());
            end
        end
    end

    initial begin
        // Reset held two cycles with requests present.
        repeat (2) @(posedge clk);
        #1;
        check("rst_y", {5'h0, y0}, 8'h00);
        check("rst_valid", {7'h0, v0}, 8'h00);
        check("rst_multi", {7'h0, m0}, 8'h00);
        check("rst_valid_rr", {7'h0, v1}, 8'h00);
        check("rst_valid_n5", {7'h0, v2}, 8'h00);
        reset = 1'b0;
        push(0, 7, 1'b1);

        // Fixed priority one-hot sweep, then all-ones, then empty.
        for (int i = 0; i < 8; i++) begin
            step(8'h01 << i, 3'b001, 1'b1);
            push(0, i, 1'b0);
        end
        step(8'hFF, 3'b001, 1'b1);
        push(0, 7, 1'b1);
        step(8'h00, 3'b001, 1'b1);
        step(8'h00, 3'b001, 1'b1);
        check("fix_empty_valid", {7'h0, v0}, 8'h00);

        // Backpressure: y=3 held while d moves to 8'h80.
        step(8'h08, 3'b001, 1'b1);
        push(0, 3, 1'b0);
        repeat (4) step(8'h80, 3'b001, 1'b0);
        step(8'h80, 3'b001, 1'b1);
        push(0, 7, 1'b0);
        step(8'h00, 3'b000, 1'b1);
        step(8'h00, 3'b000, 1'b1);
        check("bp_drain_valid", {7'h0, v0}, 8'h00);

        // Enable gating.
        step(8'h10, 3'b000, 1'b1);
        step(8'h10, 3'b000, 1'b1);
        check("en_gate_valid", {7'h0, v0}, 8'h00);

        // Round-robin fairness with all requests, then two requests.
        for (int i = 0; i < 10; i++) begin
            step(8'hFF, 3'b010, 1'b1);
            push(1, i % 8, 1'b1);
        end
        for (int i = 0; i < 4; i++) begin
            step(8'h84, 3'b010, 1'b1);
            push(1, (i % 2 == 0) ? 2 : 7, 1'b1);
        end
        step(8'h00, 3'b000, 1'b1);
        step(8'h00, 3'b000, 1'b1);
        check("rr_drain_valid", {7'h0, v1}, 8'h00);

        // N=5 wrap at N-1.
        for (int i = 0; i < 6; i++) begin
            step(8'h1F, 3'b100, 1'b1);
            push(2, i % 5, 1'b1);
        end
        step(8'h10, 3'b100, 1'b1);
        push(2, 4, 1'b0);
        step(8'h03, 3'b100, 1'b1);
        push(2, 0, 1'b1);
        step(8'h00, 3'b000, 1'b1);
        step(8'h00, 3'b000, 1'b1);
        check("n5_drain_valid", {7'h0, v2}, 8'h00);

        // Mid-operation reset under backpressure with ptr=1.
        step(8'hFF, 3'b010, 1'b1);
        push(1, 0, 1'b1);
        step(8'hFF, 3'b010, 1'b0);
        step(8'hFF, 3'b010, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        q1.delete();
        check("rst_mid_valid", {7'h0, v1}, 8'h00);
        ready = 1'b1;
        push(1, 0, 1'b1);
        step(8'h00, 3'b000, 1'b1);
        step(8'h00, 3'b000, 1'b1);
        check("rst_mid_drain", {7'h0, v1}, 8'h00);

        // Every expected result must have been presented.
        check("q_fix_left", 8'(q0.size()), 8'h00);
        check("q_rr_left", 8'(q1.size()), 8'h00);
        check("q_n5_left", 8'(q2.size()), 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
